// File: rtl/cpu_pkg.sv
// Shared CPU encodings: opcodes, FSM states, ALUOp and PCSrc codes.
// Also classifies an opcode into the instruction class that picks the FSM path.
package cpu_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned ALUOP_W = 3;
   localparam int unsigned PCSRC_W = 2;

   localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
   localparam logic [OP_W-1:0] OP_SUB  = 6'b000001;
   localparam logic [OP_W-1:0] OP_ADDI = 6'b000010;
   localparam logic [OP_W-1:0] OP_ORI  = 6'b010010;
   localparam logic [OP_W-1:0] OP_AND  = 6'b010001;
   localparam logic [OP_W-1:0] OP_SLT  = 6'b100110;
   localparam logic [OP_W-1:0] OP_SW   = 6'b110000;
   localparam logic [OP_W-1:0] OP_LW   = 6'b110001;
   localparam logic [OP_W-1:0] OP_BEQ  = 6'b110100;
   localparam logic [OP_W-1:0] OP_J    = 6'b111000;

   typedef enum logic [STATE_W-1:0] {
      ST_IF     = 3'b000,
      ST_ID     = 3'b001,
      ST_EXE_AL = 3'b110,
      ST_WB_AL  = 3'b111,
      ST_EXE_BR = 3'b101,
      ST_EXE_LS = 3'b010,
      ST_MEM    = 3'b011,
      ST_WB_LD  = 3'b100
   } state_e;

   localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b010;
   localparam logic [ALUOP_W-1:0] ALU_AND = 3'b011;
   localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b100;

   localparam logic [PCSRC_W-1:0] PC_SEQ = 2'b00;
   localparam logic [PCSRC_W-1:0] PC_BR  = 2'b01;
   localparam logic [PCSRC_W-1:0] PC_JMP = 2'b10;

   typedef enum logic [2:0] {
      IC_ALU, IC_BR, IC_LS, IC_JMP, IC_HALT, IC_NOP
   } iclass_e;

   // Listed opcodes take precedence; anything else is halt or a NOP.
   function automatic iclass_e op_class(input logic [OP_W-1:0] op,
                                        input logic [OP_W-1:0] halt_op);
      iclass_e cls;
      cls = IC_NOP;
      case (op)
         OP_ADD, OP_SUB, OP_ADDI, OP_ORI, OP_AND, OP_SLT: cls = IC_ALU;
         OP_BEQ:                                          cls = IC_BR;
         OP_LW, OP_SW:                                    cls = IC_LS;
         OP_J:                                            cls = IC_JMP;
         default: cls = (op == halt_op) ? IC_HALT : IC_NOP;
      endcase
      return cls;
   endfunction

   function automatic logic [ALUOP_W-1:0] op_aluop(input logic [OP_W-1:0] op);
      logic [ALUOP_W-1:0] aop;
      aop = ALU_ADD;
      case (op)
         OP_SUB, OP_BEQ: aop = ALU_SUB;
         OP_ORI:         aop = ALU_OR;
         OP_AND:         aop = ALU_AND;
         OP_SLT:         aop = ALU_SLT;
         default:        aop = ALU_ADD;
      endcase
      return aop;
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit bus: instruction/flag inputs and datapath control outputs.
interface control_unit_if;
   import cpu_pkg::*;

   logic [OP_W-1:0]    opcode;
   logic               zero;
   logic               PCWre;
   logic [PCSRC_W-1:0] PCSrc;
   logic               IRWre;
   logic               RegWre;
   logic               RegDst;
   logic               ALUSrcB;
   logic [ALUOP_W-1:0] ALUOp;
   logic               ExtSel;
   logic               mRD;
   logic               mWR;
   logic               DBDataSrc;
   logic [STATE_W-1:0] state;

   modport master (
      input  opcode, zero,
      output PCWre, PCSrc, IRWre, RegWre, RegDst, ALUSrcB, ALUOp,
             ExtSel, mRD, mWR, DBDataSrc, state
   );

   modport slave (
      output opcode, zero,
      input  PCWre, PCSrc, IRWre, RegWre, RegDst, ALUSrcB, ALUOp,
             ExtSel, mRD, mWR, DBDataSrc, state
   );
endinterface

// File: rtl/control_outdec.sv
// Combinational (state, opcode, zero) -> control decode.
// Reset masks the write/load strobes so nothing commits while RST is high.
module control_outdec
   import cpu_pkg::*;
#(
   parameter logic [OP_W-1:0] HALT_OP = 6'b111111
) (
   input  logic               rst,
   input  state_e             state,
   input  logic [OP_W-1:0]    opcode,
   input  logic               zero,
   output logic               pc_wre,
   output logic [PCSRC_W-1:0] pc_src,
   output logic               ir_wre,
   output logic               reg_wre,
   output logic               reg_dst,
   output logic               alu_src_b,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               ext_sel,
   output logic               m_rd,
   output logic               m_wr,
   output logic               db_data_src
);

   iclass_e cls;
   logic    imm_op;
   logic    sext_op;
   logic    rtype_op;

   always_comb begin
      pc_wre      = 1'b0;
      pc_src      = PC_SEQ;
      ir_wre      = 1'b0;
      reg_wre     = 1'b0;
      reg_dst     = 1'b0;
      alu_src_b   = 1'b0;
      alu_op      = ALU_ADD;
      ext_sel     = 1'b0;
      m_rd        = 1'b0;
      m_wr        = 1'b0;
      db_data_src = 1'b0;

      cls      = op_class(opcode, HALT_OP);
      imm_op   = opcode inside {OP_ADDI, OP_ORI, OP_LW, OP_SW};
      sext_op  = opcode inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ};
      rtype_op = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_SLT};

      // Per-instruction fields stay stable from ID to the final state.
      if (state != ST_IF) begin
         alu_op  = op_aluop(opcode);
         ext_sel = sext_op;
         reg_dst = rtype_op;
      end

      case (state)
         ST_IF: ir_wre = 1'b1;
         ST_ID: begin
            if (cls == IC_JMP) begin
               pc_wre = 1'b1;
               pc_src = PC_JMP;
            end else if (cls == IC_NOP) begin
               pc_wre = 1'b1;
            end
         end
         ST_EXE_AL, ST_EXE_LS: alu_src_b = imm_op;
         ST_EXE_BR: begin
            alu_src_b = imm_op;
            pc_wre    = 1'b1;
            pc_src    = zero ? PC_BR : PC_SEQ;
         end
         ST_WB_AL: begin
            alu_src_b = imm_op;
            reg_wre   = 1'b1;
            pc_wre    = 1'b1;
         end
         ST_MEM: begin
            if (opcode == OP_LW) begin
               m_rd = 1'b1;
            end else if (opcode == OP_SW) begin
               m_wr   = 1'b1;
               pc_wre = 1'b1;
            end
         end
         ST_WB_LD: begin
            reg_wre     = 1'b1;
            db_data_src = 1'b1;
            pc_wre      = 1'b1;
         end
         default: ;
      endcase

      if (rst) begin
         pc_wre  = 1'b0;
         ir_wre  = 1'b0;
         reg_wre = 1'b0;
         m_wr    = 1'b0;
      end
   end

endmodule

// File: rtl/control_unit.sv
// Multicycle CPU control FSM: state register and next-state logic.
// Output decode lives in control_outdec.
module control_unit
   import cpu_pkg::*;
#(
   parameter logic [OP_W-1:0] HALT_OP = 6'b111111
) (
   input  logic CLK,
   input  logic RST,
   control_unit_if.master bus
);

   state_e  state_q;
   state_e  state_d;
   iclass_e cls;

   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_IF;
      else     state_q <= state_d;
   end

   // The instruction class is only consulted in ID; later states follow the chosen path.
   always_comb begin
      state_d = state_q;
      cls     = op_class(bus.opcode, HALT_OP);
      case (state_q)
         ST_IF: state_d = ST_ID;
         ST_ID: begin
            case (cls)
               IC_ALU:  state_d = ST_EXE_AL;
               IC_BR:   state_d = ST_EXE_BR;
               IC_LS:   state_d = ST_EXE_LS;
               IC_HALT: state_d = ST_ID;
               default: state_d = ST_IF;
            endcase
         end
         ST_EXE_AL: state_d = ST_WB_AL;
         ST_WB_AL:  state_d = ST_IF;
         ST_EXE_BR: state_d = ST_IF;
         ST_EXE_LS: state_d = ST_MEM;
         ST_MEM:    state_d = (bus.opcode == OP_LW) ? ST_WB_LD : ST_IF;
         ST_WB_LD:  state_d = ST_IF;
         default:   state_d = ST_IF;
      endcase
   end

   assign bus.state = state_q;

   control_outdec #(.HALT_OP(HALT_OP)) u_outdec (
      .rst         (RST),
      .state       (state_q),
      .opcode      (bus.opcode),
      .zero        (bus.zero),
      .pc_wre      (bus.PCWre),
      .pc_src      (bus.PCSrc),
      .ir_wre      (bus.IRWre),
      .reg_wre     (bus.RegWre),
      .reg_dst     (bus.RegDst),
      .alu_src_b   (bus.ALUSrcB),
      .alu_op      (bus.ALUOp),
      .ext_sel     (bus.ExtSel),
      .m_rd        (bus.mRD),
      .m_wr        (bus.mWR),
      .db_data_src (bus.DBDataSrc)
   );

endmodule
